// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encodings and default width for multiply/divide blocks
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_n.sv
// rtl/adder_n.sv - parameterised ripple-carry adder built from full_adder cells
module adder_n #(
  parameter int N = 33
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N:0] w_carry;

  assign w_carry[0] = Cin;
  assign Cout       = w_carry[N];

  // Carry ripples from bit 0 upward through one cell per bit
  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (w_carry[i]),
      .s    (S[i]),
      .cout (w_carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of three input bits
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - iterative radix-2 Booth signed multiplier, one bit per cycle
module booth_multiplier
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int PW = 2 * WIDTH + 2;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_rdy;

  // Upper field carries one guard bit so adding -2^(WIDTH-1) cannot wrap
  logic [WIDTH:0]     w_upper;
  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_upper_next;
  logic               w_sub;
  logic               w_op;
  logic               w_cout_unused;
  logic [PW-1:0]      w_p_shift;
  logic [2*WIDTH-1:0] w_q;
  logic [WIDTH:0]     w_q_top;
  logic               w_exception;

  assign w_upper  = r_p[PW-1:WIDTH+1];
  assign w_m_ext  = {r_m[WIDTH-1], r_m};
  assign w_sub    = (r_p[1:0] == 2'b10);
  assign w_op     = r_p[1] ^ r_p[0];
  assign w_addend = w_sub ? ~w_m_ext : w_m_ext;

  adder_n #(
    .N (WIDTH + 1)
  ) u_adder (
    .A    (w_upper),
    .B    (w_addend),
    .Cin  (w_sub),
    .S    (w_sum),
    .Cout (w_cout_unused)
  );

  // Partial sum after the Booth step, then arithmetic shift right by one
  assign w_upper_next = w_op ? w_sum : w_upper;
  assign w_p_shift    = {w_upper_next[WIDTH], w_upper_next, r_p[WIDTH:1]};

  // Full product as it will stand after this step's shift
  assign w_q         = {w_upper_next, r_p[WIDTH:2]};
  assign w_q_top     = w_q[2*WIDTH-1:WIDTH-1];
  assign w_exception = ~((&w_q_top) | ~(|w_q_top));

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;

  // Control FSM: load on any start pulse, iterate WIDTH times, strobe one DONE cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_p         <= '0;
      r_m         <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (ctrl_MULT) begin
        r_state <= RUN;
        r_count <= '0;
        r_m     <= data_operandA;
        r_p     <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
      end else begin
        case (r_state)
          RUN: begin
            r_p     <= w_p_shift;
            r_count <= r_count + 1'b1;
            if (r_count == CW'(WIDTH - 1)) begin
              r_state     <= DONE;
              r_rdy       <= 1'b1;
              r_result    <= w_q[WIDTH-1:0];
              r_exception <= w_exception;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
